// File: rtl/pwm_audio_out.sv
// PWM modulator for the audio path: a free-running period counter compared against a
// double-buffered duty reference, with underrun flagging and clean start/stop sequencing.
module pwm_audio_out #(
    parameter int PERIOD = 90000
) (
    input  logic        clk,
    input  logic        reset_central,
    input  logic        enable,
    input  logic [16:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        clear_underrun,
    output logic [16:0] contador,
    output logic        period_start,
    output logic        pwm_out,
    output logic        running,
    output logic        underrun
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [16:0] PERIOD_W    = 17'(PERIOD);
    localparam logic [16:0] PERIOD_LAST = 17'(PERIOD - 1);

    state_t      state;
    logic [16:0] sample_buf;
    logic [16:0] duty_act;
    logic [16:0] duty_clamped;
    logic        buf_full;
    logic        transfer;
    logic        wrap;

    assign sample_ready = !buf_full;
    assign transfer     = sample_valid && !buf_full;
    assign wrap         = (state != IDLE) && (contador == PERIOD_LAST);
    assign duty_clamped = (duty_act > PERIOD_W) ? PERIOD_W : duty_act;
    assign running      = (state != IDLE);

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            state        <= IDLE;
            contador     <= '0;
            duty_act     <= '0;
            sample_buf   <= '0;
            buf_full     <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            pwm_out      <= (state != IDLE) && (contador < duty_clamped);
            period_start <= 1'b0;

            // Clear is written first so a same-edge underrun set takes priority.
            if (clear_underrun)
                underrun <= 1'b0;

            if (transfer) begin
                sample_buf <= sample_in;
                buf_full   <= 1'b1;
            end

            case (state)
                IDLE: begin
                    contador <= '0;
                    if (enable) begin
                        state        <= RUN;
                        period_start <= 1'b1;
                        // Only consume a sample that was already buffered; a same-edge transfer stays in the buffer.
                        if (buf_full) begin
                            duty_act <= sample_buf;
                            buf_full <= 1'b0;
                        end else begin
                            duty_act <= '0;
                        end
                    end
                end
                default: begin
                    if (wrap) begin
                        contador     <= '0;
                        period_start <= 1'b1;
                        if (state == STOP && !enable) begin
                            state <= IDLE;
                        end else begin
                            state <= enable ? RUN : STOP;
                            // Judged on the pre-edge buffer state, so a same-edge transfer still counts as underrun.
                            if (buf_full) begin
                                duty_act <= sample_buf;
                                buf_full <= 1'b0;
                            end else begin
                                underrun <= 1'b1;
                            end
                        end
                    end else begin
                        contador <= contador + 17'd1;
                        state    <= enable ? RUN : STOP;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Scoreboard bench for pwm_audio_out at PERIOD=10: stimulus queues the expected duty
// per period, a monitor captures each period's pwm_out pattern and compares.
`timescale 1ns/1ps
module tb_pwm_audio_out;

    localparam int P = 10;

    logic        clk            = 1'b0;
    logic        reset_central  = 1'b1;
    logic        enable         = 1'b0;
    logic        sample_valid   = 1'b0;
    logic        clear_underrun = 1'b0;
    logic [16:0] sample_in      = '0;
    logic        sample_ready;
    logic [16:0] contador;
    logic        period_start;
    logic        pwm_out;
    logic        running;
    logic        underrun;

    int checks   = 0;
    int failures = 0;
    int sb_q[$];

    logic        collecting = 1'b0;
    int          seen       = 0;
    int          exp_duty   = 0;
    logic [31:0] pat        = '0;
    logic [31:0] exp_pat    = '0;

    pwm_audio_out #(.PERIOD(P)) dut (
        .clk            (clk),
        .reset_central  (reset_central),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .clear_underrun (clear_underrun),
        .contador       (contador),
        .period_start   (period_start),
        .pwm_out        (pwm_out),
        .running        (running),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [16:0] value);
        sample_in    = value;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic waitCount(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (contador != 17'(v) && n < 40);
        if (contador != 17'(v)) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_contador: got %0d expected %0d", contador, v);
        end
    endtask

    // Each window samples pwm_out for the P cycles after a period_start, i.e. contador 0..P-1 lagged by one.
    always @(negedge clk) begin
        if (reset_central) begin
            collecting = 1'b0;
        end else begin
            if (collecting) begin
                pat[seen] = pwm_out;
                seen++;
                if (seen == P) begin
                    collecting = 1'b0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL period_pattern: got %0h with no expected period queued", pat);
                    end else begin
                        exp_duty = sb_q.pop_front();
                        exp_pat  = '0;
                        for (int i = 0; i < P; i++)
                            exp_pat[i] = (i < exp_duty);
                        checkOutput("period_pattern", pat, exp_pat);
                    end
                end
            end
            if (period_start && running) begin
                collecting = 1'b1;
                seen       = 0;
                pat        = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_contador", contador, 0);
        checkOutput("reset_pwm", pwm_out, 0);
        checkOutput("reset_period_start", period_start, 0);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_underrun", underrun, 0);
        checkOutput("reset_ready", sample_ready, 1);
        reset_central = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("idle_contador", contador, 0);
        checkOutput("idle_running", running, 0);
        checkOutput("idle_pwm", pwm_out, 0);

        // Basic duty: preload 3, then enable
        applyStimulus(17'd3);
        checkOutput("preload_ready", sample_ready, 0);
        sb_q.push_back(3);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("entry_contador", contador, 0);
        checkOutput("entry_period_start", period_start, 1);
        checkOutput("entry_running", running, 1);
        checkOutput("entry_ready", sample_ready, 1);
        waitCount(2);
        applyStimulus(17'd3);
        sb_q.push_back(3);

        // Double buffer: load 7 at contador 4 of the second period
        waitCount(0);
        waitCount(4);
        applyStimulus(17'd7);
        sb_q.push_back(7);
        checkOutput("dbuf_ready_c5", sample_ready, 0);
        checkOutput("dbuf_period_start_c5", period_start, 0);
        waitCount(9);
        checkOutput("dbuf_ready_c9", sample_ready, 0);
        @(negedge clk);
        checkOutput("dbuf_ready_after_wrap", sample_ready, 1);
        checkOutput("dbuf_period_start", period_start, 1);

        // Clamp and extremes
        waitCount(2);
        applyStimulus(17'd0);
        sb_q.push_back(0);
        waitCount(2);
        applyStimulus(17'd10);
        sb_q.push_back(10);
        waitCount(2);
        applyStimulus(17'd131071);
        sb_q.push_back(10);

        // Underrun: no sample during this period
        waitCount(0);
        waitCount(9);
        checkOutput("underrun_before", underrun, 0);
        sb_q.push_back(10);
        @(negedge clk);
        checkOutput("underrun_set", underrun, 1);
        waitCount(3);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        checkOutput("underrun_cleared", underrun, 0);
        waitCount(9);
        clear_underrun = 1'b1;
        sb_q.push_back(10);
        @(negedge clk);
        clear_underrun = 1'b0;
        checkOutput("underrun_set_wins", underrun, 1);
        waitCount(2);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        checkOutput("underrun_cleared2", underrun, 0);
        applyStimulus(17'd5);
        sb_q.push_back(5);

        // Stop: drop enable at contador 2, period completes, then idle
        waitCount(0);
        waitCount(2);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("stop_running", running, 1);
        waitCount(5);
        applyStimulus(17'd2);
        waitCount(0);
        checkOutput("stopped_running", running, 0);
        checkOutput("stopped_ready", sample_ready, 0);
        repeat (2) @(negedge clk);
        checkOutput("stopped_contador", contador, 0);
        checkOutput("stopped_pwm", pwm_out, 0);

        // Restart from idle, then a brief stop/re-enable inside a period
        enable = 1'b1;
        sb_q.push_back(2);
        @(negedge clk);
        checkOutput("restart_period_start", period_start, 1);
        checkOutput("restart_ready", sample_ready, 1);
        waitCount(1);
        applyStimulus(17'd6);
        sb_q.push_back(6);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("reenable_contador", contador, 4);
        checkOutput("reenable_running", running, 1);
        waitCount(0);
        checkOutput("reenable_wrap_start", period_start, 1);
        waitCount(2);
        enable = 1'b0;
        waitCount(0);
        checkOutput("final_stop_running", running, 0);
        checkOutput("final_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        // Asynchronous reset mid-period at contador 6
        enable = 1'b1;
        waitCount(6);
        #2;
        reset_central = 1'b1;
        sb_q.delete();
        #1;
        checkOutput("async_reset_contador", contador, 0);
        checkOutput("async_reset_pwm", pwm_out, 0);
        checkOutput("async_reset_period_start", period_start, 0);
        checkOutput("async_reset_running", running, 0);
        checkOutput("async_reset_underrun", underrun, 0);
        checkOutput("async_reset_ready", sample_ready, 1);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        reset_central = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_contador", contador, 0);
        checkOutput("post_reset_running", running, 0);
        checkOutput("post_reset_pwm", pwm_out, 0);
        checkOutput("post_reset_ready", sample_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

PWM modulator for the audio path. It consumes 17-bit duty references produced upstream and compares them against its own free-running period counter to drive the audio PWM pin. A one-entry double buffer with a valid/ready handshake means a new reference only takes effect at a period boundary. Underruns are flagged, and an enable-controlled state machine starts and stops the output cleanly.

## Interface
- `PERIOD`, default 90000: counter modulus in clk cycles, legal range 2..131071.
- `clk` in 1: system clock, rising edge.
- `reset_central` in 1: reset, asynchronous, active-high.
- `enable` in 1: request PWM output.
- `sample_in` in 17: duty reference, high time in clk cycles.
- `sample_valid` in 1: `sample_in` is valid.
- `sample_ready` out 1: buffer can accept; combinational, equals `!buf_full`.
- `clear_underrun` in 1: synchronous clear of `underrun`.
- `contador` out 17: current period counter.
- `period_start` out 1: one-cycle pulse when `contador` reloads to 0 in RUN/STOP.
- `pwm_out` out 1: registered PWM output.
- `running` out 1: high in RUN or STOP.
- `underrun` out 1: sticky; a period started with an empty buffer.

## Operation
- Internal registers:
  - `buf` (17) and `buf_full`: next-reference buffer.
  - `duty_act` (17): active reference.
  - FSM states IDLE, RUN, STOP.
- Handshake: a transfer occurs on the rising edge where `sample_valid && sample_ready`. It sets `buf <= sample_in` and `buf_full <= 1`. `sample_valid` while not ready is ignored; nothing is lost upstream because upstream holds the sample.
- Clamp: a stored value greater than `PERIOD` is used as `PERIOD`, which is 100% high. A value of 0 means always low.
- IDLE:
  - `contador` is held at 0, `pwm_out` is 0, `duty_act` holds its value.
  - Transfers into `buf` are still accepted.
  - On `enable`=1, go to RUN. On that edge, `duty_act <= buf_full ? buf : 0`, `buf_full <= 0`, and `contador <= 0`. No underrun is flagged on this entry.
- RUN:
  - `contador` increments by 1 each cycle. When `contador == PERIOD-1` it wraps to 0 (the wrap edge).
  - On each wrap edge:
    - If `buf_full`, then `duty_act <= buf` and `buf_full <= 0`.
    - Otherwise `duty_act` is kept and `underrun <= 1`.
  - `enable`=0 moves to STOP with no truncation of the current period.
- STOP:
  - Counting and PWM continue as in RUN.
  - On the wrap edge go to IDLE: `contador` becomes 0 and `duty_act` is not reloaded.
  - `enable`=1 before the wrap returns to RUN with no gap.
- Simultaneous events:
  - A transfer on a wrap edge with the buffer empty writes `buf` only. The wrap still sees an empty buffer, so `duty_act` is repeated and `underrun` is set.
  - `clear_underrun` on the same edge as a new underrun: set wins.
- `running` is high in RUN and STOP.
- Reset, asynchronous and valid at any time including mid-period, forces:
  - state IDLE
  - `contador` = 0, `duty_act` = 0, `buf` = 0, `buf_full` = 0
  - `pwm_out` = 0, `period_start` = 0, `underrun` = 0, `running` = 0
  - `sample_ready` = 1

## Timing
- `pwm_out <= (state != IDLE) && (contador < clamp(duty_act))`, registered. `pwm_out` therefore lags `contador` by one cycle. With duty D, 0 < D ≤ PERIOD, `pwm_out` is high for exactly D consecutive cycles per period.
- `period_start` is registered. It is high during the cycle in which `contador` == 0 following a wrap or the IDLE→RUN entry.
- Reference latency: a value accepted during period N drives `pwm_out` in period N+1. The first high cycle of `pwm_out` appears 1 cycle after `contador` == 0.
- `sample_ready` drops the cycle after a transfer and rises the cycle after the wrap edge that empties the buffer.
- Width rules:
  - All compares are 17-bit unsigned.
  - `contador` never exceeds `PERIOD-1`.

## Test plan
- **Reset/idle.** PERIOD=10. Assert `reset_central` mid-RUN with `contador`=6. Required: all outputs 0 immediately and `sample_ready`=1; after release, outputs stay idle while `enable`=0.
- **Basic duty.** PERIOD=10, preload 3, enable. Required: `pwm_out` high exactly 3 of every 10 cycles, rising 1 cycle after `contador`=0, and `period_start` every 10 cycles.
- **Double buffer.** Running at 3, load 7 at `contador`=4. Required: the current period keeps 3 high cycles, the next period has 7, and `sample_ready` is 0 from `contador`=5 until after the wrap.
- **Clamp/extremes.** Load 0, then 10, then 131071 at PERIOD=10. Required: the period with 0 is all low; the periods with 10 and 131071 are all high.
- **Underrun.** Do not supply a sample for one period. Required: duty repeats, `underrun`=1 until `clear_underrun`. Also check the set-vs-clear collision: set wins.
- **Stop/restart.** Drop `enable` at `contador`=2. Required: the period completes, then IDLE with `running`=0 and `contador`=0. Re-raising `enable` during STOP keeps counting uninterrupted.
